// File: rtl/stage_sequencer.sv
// Five-stage multicycle sequencer: steps IF/ID/EX/MEM/WB in lockstep with the
// upstream PC cadence, latches the fetched instruction and issues stage strobes.
module stage_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  pc,
    input  logic [31:0] imem_rdata,
    output logic        imem_re,
    output logic [5:0]  imem_addr,
    output logic [31:0] ir,
    output logic [2:0]  stage,
    output logic        rf_re,
    output logic        alu_en,
    output logic        mem_re,
    output logic        mem_we,
    output logic        rf_we,
    output logic [15:0] retired,
    output logic        misalign,
    output logic        illegal
);

    localparam logic [2:0] ST_IF  = 3'd0;
    localparam logic [2:0] ST_ID  = 3'd1;
    localparam logic [2:0] ST_EX  = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3;
    localparam logic [2:0] ST_WB  = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [7:0]  pc_prev;
    logic        pc_chg;
    logic        resync;
    logic [15:0] retired_cnt;
    logic        is_rtype;
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;
    logic        is_legal;
    logic        unused_pc_bits;

    // Byte offset within the word carries no information for fetch.
    assign unused_pc_bits = &{1'b0, pc[1:0]};

    assign is_rtype = (ir[31:26] == OP_RTYPE);
    assign is_lw    = (ir[31:26] == OP_LW);
    assign is_sw    = (ir[31:26] == OP_SW);
    assign is_beq   = (ir[31:26] == OP_BEQ);
    assign is_legal = is_rtype | is_lw | is_sw | is_beq;

    // A PC move anywhere before WB means upstream lost sync with us; WB is the
    // only stage where a new PC is expected to appear.
    assign pc_chg = (pc != pc_prev);
    assign resync = pc_chg && (state <= ST_MEM);

    always_comb begin
        unique case (state)
            ST_IF:   state_next = ST_ID;
            ST_ID:   state_next = ST_EX;
            ST_EX:   state_next = ST_MEM;
            ST_MEM:  state_next = ST_WB;
            default: state_next = ST_IF;
        endcase
        if (resync) begin
            state_next = ST_IF;
        end
    end

    // NOTE: reset is synchronous, so it is sampled inside the clocked branch and
    // kept out of the sensitivity list; state updates use non-blocking assigns.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IF;
            ir          <= 32'd0;
            retired_cnt <= 16'd0;
            misalign    <= 1'b0;
            illegal     <= 1'b0;
            pc_prev     <= pc;
        end else begin
            state   <= state_next;
            pc_prev <= pc;
            if (state == ST_ID) begin
                ir <= imem_rdata;
            end
            if (resync) begin
                misalign <= 1'b1;
            end
            if ((state == ST_EX) && !is_legal) begin
                illegal <= 1'b1;
            end
            // A resync landing in WB does not cancel the completing instruction.
            if ((state == ST_WB) && is_legal) begin
                retired_cnt <= retired_cnt + 16'd1;
            end
        end
    end

    // NOTE: every strobe gets a default before the case so no latch is inferred.
    always_comb begin
        imem_re = 1'b0;
        rf_re   = 1'b0;
        alu_en  = 1'b0;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        rf_we   = 1'b0;
        if (!reset) begin
            unique case (state)
                ST_IF:   imem_re = 1'b1;
                ST_ID:   rf_re   = 1'b1;
                ST_EX:   alu_en  = is_legal;
                ST_MEM: begin
                    mem_re = is_lw;
                    mem_we = is_sw;
                end
                ST_WB:   rf_we   = is_rtype | is_lw;
                default: ;
            endcase
        end
    end

    assign imem_addr = pc[7:2];
    assign stage     = state;
    assign retired   = retired_cnt;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a small synchronous instruction memory
// model plus per-scenario tasks with hand-computed expectations.
module tb_stage_sequencer;

    logic        clock;
    logic        reset;
    logic [7:0]  pc;
    logic [31:0] imem_rdata;
    logic        imem_re;
    logic [5:0]  imem_addr;
    logic [31:0] ir;
    logic [2:0]  stage;
    logic        rf_re;
    logic        alu_en;
    logic        mem_re;
    logic        mem_we;
    logic        rf_we;
    logic [15:0] retired;
    logic        misalign;
    logic        illegal;

    logic [31:0] imem [0:63];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Results of the most recent exec_one call.
    logic       r_seq_ok;
    logic [5:0] r_addr;
    int r_alu, r_mre, r_mwe, r_rfwe;
    int r_rfwe_at, r_mre_at, r_mwe_at, r_ill_at;

    stage_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .pc         (pc),
        .imem_rdata (imem_rdata),
        .imem_re    (imem_re),
        .imem_addr  (imem_addr),
        .ir         (ir),
        .stage      (stage),
        .rf_re      (rf_re),
        .alu_en     (alu_en),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .rf_we      (rf_we),
        .retired    (retired),
        .misalign   (misalign),
        .illegal    (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (imem_re) imem_rdata <= imem[imem_addr];
    end

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Runs one instruction from IF through WB, moving pc to next_pc during WB
    // the way the upstream counter does, and records what the strobes did.
    task automatic exec_one(input logic [7:0] next_pc);
        r_seq_ok = 1'b1;
        r_addr = '0;
        r_alu = 0; r_mre = 0; r_mwe = 0; r_rfwe = 0;
        r_rfwe_at = -1; r_mre_at = -1; r_mwe_at = -1; r_ill_at = -1;
        for (int c = 0; c < 5; c++) begin
            if (stage !== 3'(c)) r_seq_ok = 1'b0;
            if (imem_re !== (c == 0)) r_seq_ok = 1'b0;
            if (rf_re !== (c == 1)) r_seq_ok = 1'b0;
            if (c == 0) r_addr = imem_addr;
            if (alu_en === 1'b1) r_alu++;
            if (mem_re === 1'b1) begin r_mre++; r_mre_at = cyc; end
            if (mem_we === 1'b1) begin r_mwe++; r_mwe_at = cyc; end
            if (rf_we === 1'b1) begin r_rfwe++; r_rfwe_at = cyc; end
            if (illegal === 1'b1 && r_ill_at < 0) r_ill_at = c;
            if (c == 4) pc = next_pc;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pc = 8'd0;
        step();
        step();
        checks++; if (stage !== 3'd0) begin errors++; $display("FAIL reset_stage: got %0d expected 0", stage); end
        checks++; if (ir !== 32'd0) begin errors++; $display("FAIL reset_ir: got %h expected 00000000", ir); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
        checks++; if ({misalign, illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {misalign, illegal}); end
        checks++; if (imem_re !== 1'b0) begin errors++; $display("FAIL reset_imem_re: got %b expected 0", imem_re); end
        reset = 1'b0;
        cyc = 1;
        #1;
        checks++; if (imem_re !== 1'b1) begin errors++; $display("FAIL release_imem_re: got %b expected 1", imem_re); end
    endtask

    task automatic test_normal_run();
        exec_one(8'd4);
        checks++; if (r_seq_ok !== 1'b1) begin errors++; $display("FAIL rtype_seq: got %b expected 1", r_seq_ok); end
        checks++; if (r_addr !== 6'd0) begin errors++; $display("FAIL rtype_addr: got %0d expected 0", r_addr); end
        checks++; if (r_rfwe_at != 5) begin errors++; $display("FAIL rtype_rfwe_cycle: got %0d expected 5", r_rfwe_at); end
        checks++; if (ir !== 32'h00221820) begin errors++; $display("FAIL rtype_ir: got %h expected 00221820", ir); end
        exec_one(8'd8);
        checks++; if (r_addr !== 6'd1) begin errors++; $display("FAIL lw_addr: got %0d expected 1", r_addr); end
        checks++; if (r_mre_at != 9) begin errors++; $display("FAIL lw_mem_re_cycle: got %0d expected 9", r_mre_at); end
        checks++; if (r_rfwe_at != 10) begin errors++; $display("FAIL lw_rfwe_cycle: got %0d expected 10", r_rfwe_at); end
        exec_one(8'd12);
        checks++; if (r_addr !== 6'd2) begin errors++; $display("FAIL sw_addr: got %0d expected 2", r_addr); end
        checks++; if (r_mwe_at != 14) begin errors++; $display("FAIL sw_mem_we_cycle: got %0d expected 14", r_mwe_at); end
        checks++; if (r_rfwe != 0) begin errors++; $display("FAIL sw_rfwe_count: got %0d expected 0", r_rfwe); end
        checks++; if (retired !== 16'd3) begin errors++; $display("FAIL normal_retired: got %0d expected 3", retired); end
        checks++; if ({misalign, illegal} !== 2'b00) begin errors++; $display("FAIL normal_flags: got %b expected 00", {misalign, illegal}); end
    endtask

    task automatic test_illegal();
        exec_one(8'd16);
        checks++; if (r_ill_at != 3) begin errors++; $display("FAIL illegal_timing: got %0d expected 3", r_ill_at); end
        checks++; if (r_alu + r_mre + r_mwe + r_rfwe != 0) begin errors++; $display("FAIL illegal_strobes: got %0d expected 0", r_alu + r_mre + r_mwe + r_rfwe); end
        checks++; if (retired !== 16'd3) begin errors++; $display("FAIL illegal_retired: got %0d expected 3", retired); end
        exec_one(8'd20);
        checks++; if (r_rfwe != 1 || r_alu != 1) begin errors++; $display("FAIL after_illegal_strobes: got rfwe=%0d alu=%0d expected 1 1", r_rfwe, r_alu); end
        checks++; if (retired !== 16'd4) begin errors++; $display("FAIL after_illegal_retired: got %0d expected 4", retired); end
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b expected 1", illegal); end
    endtask

    task automatic test_misalign();
        int drops = 0;
        if (rf_we === 1'b1) drops++;
        step();
        if (rf_we === 1'b1) drops++;
        step();
        checks++; if (stage !== 3'd2) begin errors++; $display("FAIL misalign_at_ex: got %0d expected 2", stage); end
        if (rf_we === 1'b1) drops++;
        pc = 8'd40;
        step();
        if (rf_we === 1'b1) drops++;
        checks++; if (stage !== 3'd0) begin errors++; $display("FAIL misalign_resync_stage: got %0d expected 0", stage); end
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_flag: got %b expected 1", misalign); end
        checks++; if (imem_addr !== 6'd10 || imem_re !== 1'b1) begin errors++; $display("FAIL misalign_refetch: got addr=%0d re=%b expected 10 1", imem_addr, imem_re); end
        checks++; if (drops != 0) begin errors++; $display("FAIL misalign_dropped_rfwe: got %0d expected 0", drops); end
        exec_one(8'd44);
        checks++; if (r_rfwe != 1) begin errors++; $display("FAIL misalign_next_rfwe: got %0d expected 1", r_rfwe); end
        checks++; if (retired !== 16'd5) begin errors++; $display("FAIL misalign_retired: got %0d expected 5", retired); end
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got %b expected 1", misalign); end
    endtask

    task automatic test_beq();
        exec_one(8'd48);
        checks++; if (r_alu != 1) begin errors++; $display("FAIL beq_alu_count: got %0d expected 1", r_alu); end
        checks++; if (r_mre + r_mwe + r_rfwe != 0) begin errors++; $display("FAIL beq_other_strobes: got %0d expected 0", r_mre + r_mwe + r_rfwe); end
        checks++; if (retired !== 16'd6) begin errors++; $display("FAIL beq_retired: got %0d expected 6", retired); end
    endtask

    task automatic test_retired_wrap();
        dut.retired_cnt = 16'hFFFF;
        exec_one(8'd52);
        checks++; if (retired !== 16'h0000) begin errors++; $display("FAIL retired_wrap: got %h expected 0000", retired); end
        checks++; if (r_rfwe != 1) begin errors++; $display("FAIL wrap_rfwe: got %0d expected 1", r_rfwe); end
    endtask

    task automatic test_reset_mid();
        step();
        step();
        step();
        checks++; if (stage !== 3'd3 || mem_re !== 1'b1) begin errors++; $display("FAIL mid_pre_mem: got stage=%0d mem_re=%b expected 3 1", stage, mem_re); end
        reset = 1'b1;
        #1;
        checks++; if (mem_re !== 1'b0 || imem_re !== 1'b0) begin errors++; $display("FAIL mid_strobes_forced: got mem_re=%b imem_re=%b expected 0 0", mem_re, imem_re); end
        step();
        checks++; if (stage !== 3'd0 || ir !== 32'd0) begin errors++; $display("FAIL mid_reset_state: got stage=%0d ir=%h expected 0 00000000", stage, ir); end
        checks++; if (retired !== 16'd0 || {misalign, illegal} !== 2'b00) begin errors++; $display("FAIL mid_reset_counters: got retired=%0d flags=%b expected 0 00", retired, {misalign, illegal}); end
        reset = 1'b0;
        #1;
        checks++; if (imem_re !== 1'b1 || imem_addr !== 6'd13) begin errors++; $display("FAIL mid_release_fetch: got re=%b addr=%0d expected 1 13", imem_re, imem_addr); end
    endtask

    task automatic test_back_to_back();
        exec_one(8'd56);
        checks++; if (r_seq_ok !== 1'b1) begin errors++; $display("FAIL b2b_seq: got %b expected 1", r_seq_ok); end
        checks++; if (r_mre != 1 || r_rfwe != 1) begin errors++; $display("FAIL b2b_lw_strobes: got mre=%0d rfwe=%0d expected 1 1", r_mre, r_rfwe); end
        checks++; if (retired !== 16'd1) begin errors++; $display("FAIL b2b_retired: got %0d expected 1", retired); end
    endtask

    initial begin
        reset = 1'b1;
        pc = 8'd0;
        for (int i = 0; i < 64; i++) imem[i] = 32'hFC000000;
        imem[0]  = 32'h00221820;
        imem[1]  = 32'h8C220004;
        imem[2]  = 32'hAC220008;
        imem[3]  = 32'hFC000000;
        imem[4]  = 32'h00221820;
        imem[5]  = 32'h8C220004;
        imem[10] = 32'h00221820;
        imem[11] = 32'h10220003;
        imem[12] = 32'h00221820;
        imem[13] = 32'h8C220004;

        test_reset();
        test_normal_run();
        test_illegal();
        test_misalign();
        test_beq();
        test_retired_wrap();
        test_reset_mid();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
